// File: rtl/memory_arbiter_if.sv
// Datapath-side request/response and RAM-side strobe signals of memory_arbiter,
// bundled so the arbiter and its environment connect through one port.
interface memory_arbiter_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        ihit;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic [31:0] dmemload;
  logic        dhit;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;
  logic        bus_err;

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ramload, ram_ready,
    output imemload, ihit, dmemload, dhit, ramREN, ramWEN, ramaddr, ramstore, bus_err
  );

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ramload, ram_ready,
    input  imemload, ihit, dmemload, dhit, ramREN, ramWEN, ramaddr, ramstore, bus_err
  );
endinterface

// File: rtl/memory_arbiter.sv
// Shares one single-ported RAM between instruction fetch and data access:
// data wins by default, but fetch is served after every completed data access.
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic             CLK,
  input logic             nRST,
  memory_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     r_state;
  logic       r_last_d;
  logic       r_bus_err;
  logic [7:0] r_wait_cnt;

  logic       w_dreq;
  logic       w_grant_d;
  logic       w_grant_i;
  logic       w_i_live;
  logic       w_d_live;
  logic [7:0] w_wait_inc;
  logic       w_wait_done;

  // Request decode, arbitration and timeout detection
  always_comb begin
    w_dreq      = bus.dmemREN | bus.dmemWEN;
    w_grant_d   = w_dreq & ~(r_last_d & bus.imemREN);
    w_grant_i   = ~w_grant_d & bus.imemREN;
    // A grant is live only while its requester still holds the request
    w_i_live    = (r_state == IACC) & bus.imemREN;
    w_d_live    = (r_state == DACC) & w_dreq;
    w_wait_inc  = r_wait_cnt + 8'd1;
    w_wait_done = (w_wait_inc == TIMEOUT_CNT);
  end

  // RAM strobes and pipeline hits driven from the live grant
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'h0000_0000;
    bus.ramstore = 32'h0000_0000;
    bus.ihit     = 1'b0;
    bus.imemload = 32'h0000_0000;
    bus.dhit     = 1'b0;
    bus.dmemload = 32'h0000_0000;
    bus.bus_err  = r_bus_err;
    if (w_i_live) begin
      bus.ramREN  = 1'b1;
      bus.ramaddr = bus.imemaddr;
      if (bus.ram_ready) begin
        bus.ihit     = 1'b1;
        bus.imemload = bus.ramload;
      end else begin
        bus.ihit     = 1'b0;
        bus.imemload = 32'h0000_0000;
      end
    end else if (w_d_live) begin
      bus.ramWEN   = bus.dmemWEN;
      bus.ramREN   = ~bus.dmemWEN;
      bus.ramaddr  = bus.dmemaddr;
      bus.ramstore = bus.dmemstore;
      if (bus.ram_ready) begin
        bus.dhit     = 1'b1;
        bus.dmemload = bus.ramload;
      end else begin
        bus.dhit     = 1'b0;
        bus.dmemload = 32'h0000_0000;
      end
    end else begin
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = 32'h0000_0000;
      bus.ramstore = 32'h0000_0000;
    end
  end

  // Access sequencing, wait counting, round-robin history and sticky error
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_last_d   <= 1'b0;
      r_bus_err  <= 1'b0;
      r_wait_cnt <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wait_cnt <= 8'd0;
          if (w_grant_d) begin
            r_state <= DACC;
          end else if (w_grant_i) begin
            r_state <= IACC;
          end else begin
            r_state <= IDLE;
          end
        end
        IACC, DACC: begin
          if (!(w_i_live | w_d_live)) begin
            r_state    <= IDLE;
            r_wait_cnt <= 8'd0;
          end else if (bus.ram_ready) begin
            r_state    <= IDLE;
            r_last_d   <= (r_state == DACC);
            r_wait_cnt <= 8'd0;
          end else if (w_wait_done) begin
            // Abort and hand the next grant to the other requester
            r_state    <= IDLE;
            r_bus_err  <= 1'b1;
            r_last_d   <= ~r_last_d;
            r_wait_cnt <= 8'd0;
          end else begin
            r_wait_cnt <= w_wait_inc;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_wait_cnt <= 8'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, hand-written
// timeout/reset sequences, then random traffic against a transaction-level model.
module tb_memory_arbiter;
  localparam int TO = 4;

  typedef struct packed {
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        ram_ready;
    logic [31:0] ramload;
  } stim_t;

  typedef struct packed {
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic        ihit;
    logic [31:0] imemload;
    logic        dhit;
    logic [31:0] dmemload;
    logic        bus_err;
  } resp_t;

  typedef struct packed {
    stim_t stim;
    resp_t exp;
  } vec_t;

  logic CLK;
  logic nRST;
  int   n_checks = 0;
  int   n_fail   = 0;

  memory_arbiter_if bus ();

  memory_arbiter #(.TIMEOUT(TO)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic stim_t mk_stim(input logic ir, input logic [31:0] ia, input logic dr,
                                    input logic dw, input logic [31:0] da, input logic [31:0] ds,
                                    input logic rdy, input logic [31:0] rl);
    stim_t s;
    s.imemREN = ir; s.imemaddr = ia; s.dmemREN = dr; s.dmemWEN = dw;
    s.dmemaddr = da; s.dmemstore = ds; s.ram_ready = rdy; s.ramload = rl;
    return s;
  endfunction

  function automatic resp_t mk_resp(input logic ren, input logic wen, input logic [31:0] addr,
                                    input logic [31:0] store, input logic ih, input logic [31:0] il,
                                    input logic dh, input logic [31:0] dl, input logic berr);
    resp_t r;
    r.ramREN = ren; r.ramWEN = wen; r.ramaddr = addr; r.ramstore = store;
    r.ihit = ih; r.imemload = il; r.dhit = dh; r.dmemload = dl; r.bus_err = berr;
    return r;
  endfunction

  task automatic drive(input stim_t s);
    bus.imemREN   = s.imemREN;
    bus.imemaddr  = s.imemaddr;
    bus.dmemREN   = s.dmemREN;
    bus.dmemWEN   = s.dmemWEN;
    bus.dmemaddr  = s.dmemaddr;
    bus.dmemstore = s.dmemstore;
    bus.ram_ready = s.ram_ready;
    bus.ramload   = s.ramload;
  endtask

  function automatic resp_t sample();
    return mk_resp(bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.ihit,
                   bus.imemload, bus.dhit, bus.dmemload, bus.bus_err);
  endfunction

  task automatic check(input string name, input resp_t act, input resp_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ren=%0b wen=%0b addr=%h store=%h ihit=%0b iload=%h dhit=%0b dload=%h berr=%0b | expected ren=%0b wen=%0b addr=%h store=%h ihit=%0b iload=%h dhit=%0b dload=%h berr=%0b",
               name, act.ramREN, act.ramWEN, act.ramaddr, act.ramstore, act.ihit, act.imemload,
               act.dhit, act.dmemload, act.bus_err, exp.ramREN, exp.ramWEN, exp.ramaddr,
               exp.ramstore, exp.ihit, exp.imemload, exp.dhit, exp.dmemload, exp.bus_err);
    end
  endtask

  // One clock cycle: drive after the edge, check combinational outputs mid-cycle
  task automatic apply(input string name, input stim_t s, input resp_t e);
    @(posedge CLK);
    #1;
    drive(s);
    #2;
    check(name, sample(), e);
  endtask

  // Transaction-level reference: who owns the RAM, how long it has waited,
  // who was served last, and whether any access has ever been abandoned.
  localparam int OWN_NONE = 0;
  localparam int OWN_I    = 1;
  localparam int OWN_D    = 2;
  int m_owner;
  int m_waited;
  bit m_last_d;
  bit m_bus_err;

  task automatic model_reset();
    m_owner = OWN_NONE; m_waited = 0; m_last_d = 1'b0; m_bus_err = 1'b0;
  endtask

  function automatic bit owner_still_asking();
    if (m_owner == OWN_I) return bus.imemREN;
    if (m_owner == OWN_D) return bus.dmemREN || bus.dmemWEN;
    return 1'b0;
  endfunction

  task automatic model_expect(output resp_t e);
    e = '0;
    e.bus_err = m_bus_err;
    if (owner_still_asking()) begin
      if (m_owner == OWN_I) begin
        e.ramREN = 1'b1;
        e.ramaddr = bus.imemaddr;
        e.ihit = bus.ram_ready;
        e.imemload = bus.ram_ready ? bus.ramload : 32'h0;
      end else begin
        e.ramWEN = bus.dmemWEN;
        e.ramREN = !bus.dmemWEN;
        e.ramaddr = bus.dmemaddr;
        e.ramstore = bus.dmemstore;
        e.dhit = bus.ram_ready;
        e.dmemload = bus.ram_ready ? bus.ramload : 32'h0;
      end
    end
  endtask

  task automatic model_advance();
    bit want_d;
    want_d = bus.dmemREN || bus.dmemWEN;
    if (m_owner == OWN_NONE) begin
      m_waited = 0;
      if (want_d && !(m_last_d && bus.imemREN)) m_owner = OWN_D;
      else if (bus.imemREN) m_owner = OWN_I;
    end else if (!owner_still_asking()) begin
      m_owner = OWN_NONE;
    end else if (bus.ram_ready) begin
      m_last_d = (m_owner == OWN_D);
      m_owner = OWN_NONE;
    end else begin
      m_waited++;
      if (m_waited >= TO) begin
        m_bus_err = 1'b1;
        m_last_d = !m_last_d;
        m_owner = OWN_NONE;
      end
    end
  endtask

  vec_t  tbl[$];
  stim_t s;
  resp_t e;
  resp_t z;

  function automatic vec_t mk_vec(input stim_t st, input resp_t ex);
    vec_t v;
    v.stim = st; v.exp = ex;
    return v;
  endfunction

  initial begin
    bit i_req, d_rd, d_wr;
    z = '0;

    // Directed table: one row per cycle, starting in IDLE with last_d=0, bus_err=0
    tbl.push_back(mk_vec(mk_stim(1, 32'h40, 0, 0, 0, 0, 0, 0), z));
    tbl.push_back(mk_vec(mk_stim(1, 32'h40, 0, 0, 0, 0, 0, 0), mk_resp(1, 0, 32'h40, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk_vec(mk_stim(1, 32'h40, 0, 0, 0, 0, 0, 32'h99999999), mk_resp(1, 0, 32'h40, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk_vec(mk_stim(1, 32'h40, 0, 0, 0, 0, 1, 32'hDEADBEEF), mk_resp(1, 0, 32'h40, 0, 1, 32'hDEADBEEF, 0, 0, 0)));
    tbl.push_back(mk_vec(mk_stim(0, 0, 0, 0, 0, 0, 1, 32'h77), z));
    tbl.push_back(mk_vec(mk_stim(1, 32'h80, 1, 0, 32'h200, 32'h55, 0, 0), z));
    tbl.push_back(mk_vec(mk_stim(1, 32'h80, 1, 0, 32'h200, 32'h55, 1, 32'hCAFE0001), mk_resp(1, 0, 32'h200, 32'h55, 0, 0, 1, 32'hCAFE0001, 0)));
    tbl.push_back(mk_vec(mk_stim(1, 32'h80, 1, 0, 32'h204, 32'h55, 0, 0), z));
    tbl.push_back(mk_vec(mk_stim(1, 32'h80, 1, 0, 32'h204, 32'h55, 1, 32'h11111111), mk_resp(1, 0, 32'h80, 0, 1, 32'h11111111, 0, 0, 0)));
    tbl.push_back(mk_vec(mk_stim(0, 0, 1, 0, 32'h204, 32'h55, 0, 0), z));
    tbl.push_back(mk_vec(mk_stim(0, 0, 1, 0, 32'h204, 32'h55, 1, 32'h22222222), mk_resp(1, 0, 32'h204, 32'h55, 0, 0, 1, 32'h22222222, 0)));
    tbl.push_back(mk_vec(mk_stim(0, 0, 1, 1, 32'h100, 32'h12345678, 0, 0), z));
    tbl.push_back(mk_vec(mk_stim(0, 0, 1, 1, 32'h100, 32'h12345678, 0, 0), mk_resp(0, 1, 32'h100, 32'h12345678, 0, 0, 0, 0, 0)));
    tbl.push_back(mk_vec(mk_stim(0, 0, 1, 1, 32'h100, 32'h12345678, 1, 32'h0BADF00D), mk_resp(0, 1, 32'h100, 32'h12345678, 0, 0, 1, 32'h0BADF00D, 0)));
    tbl.push_back(mk_vec(mk_stim(1, 32'h300, 0, 0, 0, 0, 0, 0), z));
    tbl.push_back(mk_vec(mk_stim(1, 32'h300, 0, 0, 0, 0, 0, 0), mk_resp(1, 0, 32'h300, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk_vec(mk_stim(0, 32'h300, 0, 0, 0, 0, 1, 32'h33333333), z));
    tbl.push_back(mk_vec(mk_stim(1, 32'h304, 1, 0, 32'h208, 0, 0, 0), z));
    tbl.push_back(mk_vec(mk_stim(1, 32'h304, 1, 0, 32'h208, 0, 1, 32'h44444444), mk_resp(1, 0, 32'h304, 0, 1, 32'h44444444, 0, 0, 0)));
    tbl.push_back(mk_vec(mk_stim(0, 0, 0, 0, 0, 0, 0, 0), z));
    tbl.push_back(mk_vec(mk_stim(0, 0, 0, 1, 32'h10C, 32'hAAAA5555, 0, 0), z));
    tbl.push_back(mk_vec(mk_stim(0, 0, 0, 0, 32'h10C, 32'hAAAA5555, 1, 32'h1234), z));
    tbl.push_back(mk_vec(mk_stim(0, 0, 0, 0, 0, 0, 0, 0), z));

    // Reset holds every output low even with requests and ram_ready present
    nRST = 1'b0;
    drive(mk_stim(1, 32'hFFFF0000, 1, 1, 32'h1234, 32'h5678, 1, 32'hFFFFFFFF));
    #3;
    check("reset_outputs", sample(), z);
    drive('0);
    @(negedge CLK);
    nRST = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      apply($sformatf("vec%0d", k), tbl[k].stim, tbl[k].exp);
    end

    // Timeout: D granted first, RAM never ready, abort after TO DACC cycles
    s = mk_stim(1, 32'h500, 1, 0, 32'h400, 0, 0, 0);
    apply("to_idle", s, z);
    for (int k = 0; k < TO; k++) begin
      apply($sformatf("to_wait%0d", k), s, mk_resp(1, 0, 32'h400, 0, 0, 0, 0, 0, 0));
    end
    apply("to_abort_idle", s, mk_resp(0, 0, 0, 0, 0, 0, 0, 0, 1));
    apply("to_i_next", mk_stim(1, 32'h500, 1, 0, 32'h400, 0, 1, 32'h5A5A),
          mk_resp(1, 0, 32'h500, 0, 1, 32'h5A5A, 0, 0, 1));
    apply("to_sticky0", mk_stim(0, 0, 0, 0, 0, 0, 0, 0), mk_resp(0, 0, 0, 0, 0, 0, 0, 0, 1));
    apply("to_sticky1", mk_stim(0, 0, 0, 0, 0, 0, 1, 32'h1), mk_resp(0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Reset in the middle of a data access
    s = mk_stim(0, 0, 1, 0, 32'h700, 0, 0, 0);
    apply("rst_idle", s, mk_resp(0, 0, 0, 0, 0, 0, 0, 0, 1));
    apply("rst_dacc", s, mk_resp(1, 0, 32'h700, 0, 0, 0, 0, 0, 1));
    #1;
    nRST = 1'b0;
    #1;
    check("rst_mid_dacc", sample(), z);
    drive('0);
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    apply("rst_after_idle", mk_stim(1, 32'h600, 0, 0, 0, 0, 0, 0), z);
    apply("rst_after_hit", mk_stim(1, 32'h600, 0, 0, 0, 0, 1, 32'hABCD),
          mk_resp(1, 0, 32'h600, 0, 1, 32'hABCD, 0, 0, 0));
    apply("rst_after_done", mk_stim(0, 0, 0, 0, 0, 0, 0, 0), z);

    // Random traffic against the reference model
    nRST = 1'b0;
    drive('0);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge CLK);
      #1;
      if (!i_req) i_req = ($urandom_range(0, 1) == 1);
      else if ($urandom_range(0, 15) == 0) i_req = 1'b0;
      if (!(d_rd || d_wr)) begin
        d_rd = ($urandom_range(0, 2) == 0);
        d_wr = ($urandom_range(0, 3) == 0);
      end else if ($urandom_range(0, 15) == 0) begin
        d_rd = 1'b0; d_wr = 1'b0;
      end
      drive(mk_stim(i_req, $urandom, d_rd, d_wr, $urandom, $urandom,
                    $urandom_range(0, 2) == 0, $urandom));
      #2;
      model_expect(e);
      check("random", sample(), e);
      model_advance();
      if (e.ihit) i_req = 1'b0;
      if (e.dhit) begin
        d_rd = 1'b0; d_wr = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
